// File: rtl/rma_pkg.sv
// Shared constants and types for the RV32I subset sequencer.
// Opcode/funct fields, ALU encodings and FSM state encoding.
package rma_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_ADDI,
        OP_ADD,
        OP_BEQ,
        OP_BNE
    } op_t;

endpackage

// File: rtl/rma_imm_gen.sv
// Combinational immediate generator.
// Picks the I-type or B-type sign-extended immediate by opcode.
module rma_imm_gen
    import rma_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    logic [6:0] opc;

    assign opc = instr[6:0];

    always_comb begin
        imm = '0;
        unique case (1'b1)
            (opc == OPC_OPIMM): begin
                imm = {{20{instr[31]}}, instr[31:20]};
            end
            (opc == OPC_BRANCH): begin
                imm = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            end
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rma_sequencer.sv
// Multi-cycle fetch/decode/exec sequencer for ADDI, ADD, BEQ, BNE.
// Drives register-file/ALU controls and steers the PC on branches.
module rma_sequencer
    import rma_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_data,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    input  logic                     eq,
    output logic [PC_WIDTH-1:0]      pc,
    output logic                     halt
);

    seq_state_t state, state_nx;

    logic [31:0]         ir;
    logic [31:0]         imm32;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] off_q;
    logic                req_q;
    logic                legal;
    logic                taken;
    op_t                 op_q;
    op_t                 op_dec;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];

    rma_imm_gen u_imm (
        .instr (ir),
        .imm   (imm32)
    );

    always_comb begin
        legal  = 1'b0;
        op_dec = OP_ADDI;
        unique case (1'b1)
            (opc == OPC_OPIMM && f3 == F3_ADD): begin
                legal  = 1'b1;
                op_dec = OP_ADDI;
            end
            (opc == OPC_OP && f3 == F3_ADD && f7 == F7_ADD): begin
                legal  = 1'b1;
                op_dec = OP_ADD;
            end
            (opc == OPC_BRANCH && f3 == F3_BEQ): begin
                legal  = 1'b1;
                op_dec = OP_BEQ;
            end
            (opc == OPC_BRANCH && f3 == F3_BNE): begin
                legal  = 1'b1;
                op_dec = OP_BNE;
            end
            default: ;
        endcase
    end

    assign taken = (op_q == OP_BEQ && eq) || (op_q == OP_BNE && !eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   if (req_q && imem_ack) state_nx = DECODE;
            DECODE:  state_nx = legal ? EXEC : HALT;
            EXEC:    state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // req is registered so it stays low while reset is held and
    // rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            req_q   <= 1'b0;
            pc_q    <= RESET_PC;
            off_q   <= '0;
            op_q    <= OP_ADDI;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
            ImmOp   <= '0;
            ALUsrc  <= 1'b0;
            ALUctrl <= ALU_ADD;
        end else begin
            case (state)
                FETCH: begin
                    if (req_q && imem_ack) begin
                        ir    <= imem_data;
                        req_q <= 1'b0;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        op_q   <= op_dec;
                        rs1    <= ADDRESS_WIDTH'(ir[19:15]);
                        rs2    <= ADDRESS_WIDTH'(ir[24:20]);
                        rd     <= ADDRESS_WIDTH'(ir[11:7]);
                        off_q  <= PC_WIDTH'($signed(imm32));
                        ALUsrc <= (op_dec == OP_ADDI);
                        if (op_dec == OP_ADD) ImmOp <= '0;
                        else ImmOp <= DATA_WIDTH'($signed(imm32));
                        if (op_dec == OP_BEQ || op_dec == OP_BNE)
                            ALUctrl <= ALU_SUB;
                        else
                            ALUctrl <= ALU_ADD;
                    end
                end
                EXEC: begin
                    pc_q  <= taken ? pc_q + off_q : pc_q + PC_WIDTH'(4);
                    req_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign RegWrite  = (state == EXEC) && (op_q == OP_ADDI || op_q == OP_ADD);
    assign halt      = (state == HALT);
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

endmodule
